// File: rtl/cam_ctrl.sv
// Request-side CAM controller: sequences LOOKUP/INSERT/DELETE/CLEAR commands
// into CAM search/write cycles, tracks occupancy with a bitmap and returns
// status/index over a valid/ready response channel.
module cam_ctrl #(
  parameter int unsigned KEY_WIDTH  = 32,
  parameter int unsigned KEY_DEPTH  = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(KEY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [KEY_WIDTH-1:0]  req_key,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_status,
  output logic [ADDR_WIDTH-1:0] resp_index,
  output logic [ADDR_WIDTH:0]   occ_count,
  output logic [ADDR_WIDTH-1:0] cam_addr,
  output logic                  cam_addr_vld,
  output logic                  cam_we,
  output logic [KEY_WIDTH-1:0]  cam_data,
  output logic                  cam_data_vld,
  input  logic                  cam_hit,
  input  logic [ADDR_WIDTH-1:0] cam_hit_addr
);

  localparam int unsigned OCC_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_WRITE, S_CLEAR, S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0, OP_INSERT = 2'd1, OP_DELETE = 2'd2, OP_CLEAR = 2'd3
  } op_e;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_DUP      = 2'd1;
  localparam logic [1:0] ST_NOTFOUND = 2'd2;
  localparam logic [1:0] ST_FULL     = 2'd3;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [KEY_DEPTH-1:0]  bitmap_q, bitmap_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [1:0]            resp_status_q, resp_status_d;
  logic [ADDR_WIDTH-1:0] resp_index_q, resp_index_d;
  logic [ADDR_WIDTH-1:0] cam_addr_q, cam_addr_d;
  logic                  cam_addr_vld_q, cam_addr_vld_d;
  logic                  cam_we_q, cam_we_d;
  logic [KEY_WIDTH-1:0]  cam_data_q, cam_data_d;
  logic                  cam_data_vld_q, cam_data_vld_d;

  logic [ADDR_WIDTH-1:0] free_idx;
  logic                  full;

  // Lowest clear bitmap position is the next allocation slot.
  always_comb begin
    free_idx = '0;
    for (int i = int'(KEY_DEPTH) - 1; i >= 0; i--) begin
      if (!bitmap_q[i]) free_idx = ADDR_WIDTH'(i);
    end
  end

  assign full = (occ_q == OCC_W'(KEY_DEPTH));

  // Occupancy count is the popcount of the next bitmap, so both update together.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(KEY_DEPTH); i++) begin
      occ_d = occ_d + OCC_W'(bitmap_d[i]);
    end
  end

  // Next-state and next-output logic; CAM strobes default low every cycle.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    key_d          = key_q;
    target_d       = target_q;
    cnt_d          = cnt_q;
    bitmap_d       = bitmap_q;
    resp_valid_d   = resp_valid_q;
    resp_status_d  = resp_status_q;
    resp_index_d   = resp_index_q;
    cam_addr_d     = '0;
    cam_addr_vld_d = 1'b0;
    cam_we_d       = 1'b0;
    cam_data_d     = '0;
    cam_data_vld_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d  = op_e'(req_op);
          key_d = req_key;
          if (op_e'(req_op) == OP_CLEAR) begin
            state_d        = S_CLEAR;
            cnt_d          = '0;
            cam_addr_vld_d = 1'b1;
            cam_we_d       = 1'b1;
          end else begin
            state_d        = S_SEARCH;
            cam_data_d     = req_key;
            cam_data_vld_d = 1'b1;
          end
        end
      end

      S_SEARCH: begin
        state_d       = S_RESP;
        resp_valid_d  = 1'b1;
        resp_status_d = ST_OK;
        resp_index_d  = '0;
        unique case (op_q)
          OP_LOOKUP: begin
            if (cam_hit) resp_index_d  = cam_hit_addr;
            else         resp_status_d = ST_NOTFOUND;
          end
          OP_INSERT: begin
            if (cam_hit) begin
              resp_status_d = ST_DUP;
              resp_index_d  = cam_hit_addr;
            end else if (full) begin
              resp_status_d = ST_FULL;
            end else begin
              state_d        = S_WRITE;
              resp_valid_d   = 1'b0;
              target_d       = free_idx;
              cam_addr_d     = free_idx;
              cam_addr_vld_d = 1'b1;
              cam_we_d       = 1'b1;
              cam_data_d     = key_q;
              cam_data_vld_d = 1'b1;
            end
          end
          OP_DELETE: begin
            if (cam_hit) begin
              state_d        = S_WRITE;
              resp_valid_d   = 1'b0;
              target_d       = cam_hit_addr;
              cam_addr_d     = cam_hit_addr;
              cam_addr_vld_d = 1'b1;
              cam_we_d       = 1'b1;
            end else begin
              resp_status_d = ST_NOTFOUND;
            end
          end
          default: ;
        endcase
      end

      S_WRITE: begin
        bitmap_d[target_q] = (op_q == OP_INSERT);
        state_d            = S_RESP;
        resp_valid_d       = 1'b1;
        resp_status_d      = ST_OK;
        resp_index_d       = target_q;
      end

      S_CLEAR: begin
        bitmap_d[cnt_q] = 1'b0;
        if (cnt_q == ADDR_WIDTH'(KEY_DEPTH - 1)) begin
          state_d       = S_RESP;
          resp_valid_d  = 1'b1;
          resp_status_d = ST_OK;
          resp_index_d  = '0;
        end else begin
          cnt_d          = cnt_q + ADDR_WIDTH'(1);
          cam_addr_d     = cnt_q + ADDR_WIDTH'(1);
          cam_addr_vld_d = 1'b1;
          cam_we_d       = 1'b1;
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          state_d       = S_IDLE;
          resp_valid_d  = 1'b0;
          resp_status_d = ST_OK;
          resp_index_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // State, bitmap and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= OP_LOOKUP;
      key_q          <= '0;
      target_q       <= '0;
      cnt_q          <= '0;
      bitmap_q       <= '0;
      occ_q          <= '0;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_status_q  <= '0;
      resp_index_q   <= '0;
      cam_addr_q     <= '0;
      cam_addr_vld_q <= 1'b0;
      cam_we_q       <= 1'b0;
      cam_data_q     <= '0;
      cam_data_vld_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      key_q          <= key_d;
      target_q       <= target_d;
      cnt_q          <= cnt_d;
      bitmap_q       <= bitmap_d;
      occ_q          <= occ_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_status_q  <= resp_status_d;
      resp_index_q   <= resp_index_d;
      cam_addr_q     <= cam_addr_d;
      cam_addr_vld_q <= cam_addr_vld_d;
      cam_we_q       <= cam_we_d;
      cam_data_q     <= cam_data_d;
      cam_data_vld_q <= cam_data_vld_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_status  = resp_status_q;
  assign resp_index   = resp_index_q;
  assign occ_count    = occ_q;
  assign cam_addr     = cam_addr_q;
  assign cam_addr_vld = cam_addr_vld_q;
  assign cam_we       = cam_we_q;
  assign cam_data     = cam_data_q;
  assign cam_data_vld = cam_data_vld_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: behavioural CAM attached to the CAM ports, directed
// scenarios followed by random commands checked against a key-table model.
module tb_cam_ctrl;

  localparam int unsigned KW = 32;
  localparam int unsigned KD = 16;
  localparam int unsigned AW = 4;

  localparam logic [1:0] OP_LKP = 2'd0, OP_INS = 2'd1, OP_DEL = 2'd2, OP_CLR = 2'd3;
  localparam logic [1:0] S_OK = 2'd0, S_DUP = 2'd1, S_NF = 2'd2, S_FULL = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [KW-1:0] req_key;
  logic          resp_valid;
  logic          resp_ready;
  logic [1:0]    resp_status;
  logic [AW-1:0] resp_index;
  logic [AW:0]   occ_count;
  logic [AW-1:0] cam_addr;
  logic          cam_addr_vld;
  logic          cam_we;
  logic [KW-1:0] cam_data;
  logic          cam_data_vld;
  logic          cam_hit;
  logic [AW-1:0] cam_hit_addr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cam_ctrl #(.KEY_WIDTH(KW), .KEY_DEPTH(KD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_status(resp_status), .resp_index(resp_index), .occ_count(occ_count),
    .cam_addr(cam_addr), .cam_addr_vld(cam_addr_vld), .cam_we(cam_we),
    .cam_data(cam_data), .cam_data_vld(cam_data_vld),
    .cam_hit(cam_hit), .cam_hit_addr(cam_hit_addr)
  );

  // Behavioural CAM array: combinational lowest-index match, write on clock.
  logic [KW-1:0] cam_mem [KD];
  logic          cam_mv  [KD];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(KD); i++) begin
        cam_mem[i] <= '0;
        cam_mv[i]  <= 1'b0;
      end
    end else if (cam_we && cam_addr_vld) begin
      cam_mem[cam_addr] <= cam_data;
      cam_mv[cam_addr]  <= cam_data_vld;
    end
  end

  always_comb begin
    cam_hit      = 1'b0;
    cam_hit_addr = '0;
    for (int i = int'(KD) - 1; i >= 0; i--) begin
      if (cam_data_vld && cam_mv[i] && cam_mem[i] == cam_data) begin
        cam_hit      = 1'b1;
        cam_hit_addr = AW'(i);
      end
    end
  end

  // Record every CAM write address the controller issues.
  int wr_q[$];
  always @(posedge clk) begin
    if (rst_n && cam_we && cam_addr_vld) wr_q.push_back(int'(cam_addr));
  end

  // Reference model: table of stored keys.
  logic [KW-1:0] mk [KD];
  bit            mv [KD];

  function automatic int m_find(input logic [KW-1:0] key);
    for (int i = 0; i < int'(KD); i++) if (mv[i] && mk[i] == key) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < int'(KD); i++) c += int'(mv[i]);
    return c;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < int'(KD); i++) begin
      mv[i] = 1'b0;
      mk[i] = '0;
    end
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Issue one command, check latency, response, writes and occupancy.
  task automatic do_cmd(input logic [1:0] op, input logic [KW-1:0] key, input int hold);
    int f, lat, w, exp_lat, exp_idx, exp_wr, exp_waddr, inorder;
    logic [1:0] exp_st, st0;
    logic [AW-1:0] ix0;
    bit bad;

    f = m_find(key);
    exp_st = S_OK; exp_idx = 0; exp_lat = 2; exp_wr = 0; exp_waddr = 0;
    case (op)
      OP_LKP: begin
        if (f >= 0) exp_idx = f; else exp_st = S_NF;
      end
      OP_INS: begin
        if (f >= 0) begin
          exp_st = S_DUP; exp_idx = f;
        end else if (m_count() == int'(KD)) begin
          exp_st = S_FULL;
        end else begin
          for (int i = int'(KD) - 1; i >= 0; i--) if (!mv[i]) exp_idx = i;
          exp_lat = 3; exp_wr = 1; exp_waddr = exp_idx;
          mk[exp_idx] = key; mv[exp_idx] = 1'b1;
        end
      end
      OP_DEL: begin
        if (f >= 0) begin
          exp_idx = f; exp_lat = 3; exp_wr = 1; exp_waddr = f;
          mv[f] = 1'b0;
        end else begin
          exp_st = S_NF;
        end
      end
      default: begin
        exp_lat = int'(KD) + 1; exp_wr = int'(KD);
        m_clear();
      end
    endcase

    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk); w++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 0, 1);
      return;
    end

    wr_q.delete();
    req_valid = 1'b1; req_op = op; req_key = key;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk($sformatf("latency op%0d", op), lat, exp_lat);
    if (!resp_valid) return;

    st0 = resp_status; ix0 = resp_index; bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!resp_valid || resp_status != st0 || resp_index != ix0 || req_ready) bad = 1'b1;
    end
    if (hold > 0) chk("resp_hold_stable", longint'(bad), 0);

    chk("req_ready_low_in_resp", req_ready, 0);
    chk($sformatf("status op%0d key%0h", op, key), resp_status, exp_st);
    chk($sformatf("index op%0d key%0h", op, key), resp_index, exp_idx);

    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_drop", resp_valid, 0);
    chk("req_ready_after_resp", req_ready, 1);
    chk("occ_count", occ_count, m_count());
    chk("cam_write_count", wr_q.size(), exp_wr);
    if (exp_wr == 1 && wr_q.size() == 1) chk("cam_write_addr", wr_q[0], exp_waddr);
    if (exp_wr == int'(KD)) begin
      inorder = 0;
      for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] == i) inorder++;
      chk("clear_addr_sequence", inorder, int'(KD));
    end
  endtask

  // INSERT an absent key and assert reset while the controller is in WRITE.
  task automatic reset_mid_write(input logic [KW-1:0] key);
    int w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk); w++;
    end
    req_valid = 1'b1; req_op = OP_INS; req_key = key;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("write_cycle_we", cam_we, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {req_ready, resp_valid, resp_status, resp_index, occ_count, cam_addr,
         cam_addr_vld, cam_we, cam_data, cam_data_vld}, 0);
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_occ", occ_count, 0);
    chk("post_reset_no_resp", resp_valid, 0);
    chk("post_reset_ready", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0] op;
    logic [KW-1:0] key;
    int r;

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_key = '0; resp_ready = 1'b0;
    m_clear();
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {req_ready, resp_valid, resp_status, resp_index, occ_count, cam_addr,
         cam_addr_vld, cam_we, cam_data, cam_data_vld}, 0);
    rst_n = 1'b1;

    do_cmd(OP_INS, 32'hDEADBEEF, 0);
    do_cmd(OP_LKP, 32'hDEADBEEF, 0);
    do_cmd(OP_INS, 32'hDEADBEEF, 0);
    do_cmd(OP_CLR, 32'h0, 0);
    for (int k = 0; k < int'(KD); k++) do_cmd(OP_INS, KW'(k), 0);
    do_cmd(OP_INS, 32'h100, 0);
    do_cmd(OP_DEL, 32'h5, 0);
    do_cmd(OP_INS, 32'h100, 0);
    do_cmd(OP_DEL, 32'hAAAA, 0);
    do_cmd(OP_LKP, 32'h0, 0);
    do_cmd(OP_CLR, 32'h0, 0);
    do_cmd(OP_LKP, 32'h7, 0);
    do_cmd(OP_INS, 32'h0, 0);
    do_cmd(OP_LKP, 32'h0, 5);
    reset_mid_write(32'h5555);
    do_cmd(OP_LKP, 32'h0, 0);

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35)      op = OP_LKP;
      else if (r < 70) op = OP_INS;
      else if (r < 97) op = OP_DEL;
      else             op = OP_CLR;
      if ($urandom_range(0, 9) == 0) key = KW'($urandom());
      else                           key = KW'($urandom_range(0, 23));
      do_cmd(op, key, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
